// File: rtl/spi_minion_chan_mux.sv
// Purpose : one SPI minion pad set fanned out to NUM_CH channels; each frame pushes
//           {data} to the selected channel, then that channel's response is pulled.
// Latency : frame accepted ~4 clk after cs rise; response returned on MISO next frame.
// Backpr. : push_val/push_msg held until push_rdy; frames arriving while busy are dropped.
//
// Ports   : clk/reset (async, active low); spi_min_{cs,sclk,mosi} async SPI inputs;
//           spi_min_miso/miso_oeb pad outputs; loopthrough_sel echo mode;
//           push_{val,msg,rdy} per-channel push; pull_{val,msg,rdy} per-channel response;
//           minion_parity = XOR of last pushed payload; err_count saturating errors.
module spi_minion_chan_mux #(
  parameter int NUM_CH    = 4,
  parameter int DATA_BITS = 32,
  parameter int ERR_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_min_cs,
  input  logic                        spi_min_sclk,
  input  logic                        spi_min_mosi,
  output logic                        spi_min_miso,
  output logic                        miso_oeb,
  input  logic                        loopthrough_sel,
  output logic [NUM_CH-1:0]           push_val,
  output logic [DATA_BITS-1:0]        push_msg,
  input  logic [NUM_CH-1:0]           push_rdy,
  input  logic [NUM_CH-1:0]           pull_val,
  input  logic [NUM_CH*DATA_BITS-1:0] pull_msg,
  output logic [NUM_CH-1:0]           pull_rdy,
  output logic                        minion_parity,
  output logic [ERR_W-1:0]            err_count
);

  localparam int SEL_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int FRAME_BITS = 1 + SEL_W + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, PUSH, PULL} state_e;

  // Synchronisers and edge detection
  logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic       cs_prev_q, sclk_prev_q;
  logic       cs_s, sclk_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_min_cs};
      sclk_sync_q <= {sclk_sync_q[0], spi_min_sclk};
      mosi_sync_q <= {mosi_sync_q[0], spi_min_mosi};
      cs_prev_q   <= cs_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign cs_s      = cs_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // Serial shift registers and bit counter
  logic [FRAME_BITS-1:0] rx_sr_q, miso_sr_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  pend_val_q;
  logic [SEL_W-1:0]      pend_chan_q;
  logic [DATA_BITS-1:0]  pend_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sr_q   <= '0;
      miso_sr_q <= '0;
      bit_cnt_q <= '0;
    end else if (cs_fall) begin
      bit_cnt_q <= '0;
      miso_sr_q <= {pend_val_q, pend_chan_q, pend_data_q};
    end else if (!cs_s) begin
      if (sclk_rise) begin
        // Bits past the frame length only move the counter to its saturation value
        if (bit_cnt_q < CNT_FULL) rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (sclk_fall) miso_sr_q <= {miso_sr_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Frame decode
  logic                 rx_val, sel_ok, frame_done, frame_ok, err_evt;
  logic [SEL_W-1:0]     rx_sel;
  logic [DATA_BITS-1:0] rx_data;
  state_e               state_q;

  assign rx_val     = rx_sr_q[FRAME_BITS-1];
  assign rx_sel     = rx_sr_q[DATA_BITS +: SEL_W];
  assign rx_data    = rx_sr_q[DATA_BITS-1:0];
  assign sel_ok     = (int'(rx_sel) < NUM_CH);
  // Loopthrough frames are invisible to the control path
  assign frame_done = cs_rise & ~loopthrough_sel;
  assign frame_ok   = frame_done && (bit_cnt_q == CNT_FULL) && (state_q == IDLE);
  assign err_evt    = frame_done & ~(frame_ok & sel_ok);

  // Saturating error counter
  logic [ERR_W-1:0] err_q, err_d;
  assign err_d = (err_evt && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  function automatic logic [NUM_CH-1:0] chan_onehot(input logic [SEL_W-1:0] s);
    return NUM_CH'(1) << s;
  endfunction

  // pull_rdy_q is one-hot on the selected channel during PULL, so it doubles as the mux select
  logic [NUM_CH-1:0]    push_val_q, pull_rdy_q;
  logic [DATA_BITS-1:0] push_msg_q, pull_sel_msg;
  logic [SEL_W-1:0]     sel_q;
  logic                 parity_q;

  always_comb begin
    pull_sel_msg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pull_rdy_q[i]) pull_sel_msg = pull_msg[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      push_val_q  <= '0;
      push_msg_q  <= '0;
      pull_rdy_q  <= '0;
      parity_q    <= 1'b0;
      pend_val_q  <= 1'b0;
      pend_chan_q <= '0;
      pend_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_ok && sel_ok) begin
            sel_q <= rx_sel;
            if (rx_val) begin
              state_q    <= PUSH;
              push_val_q <= chan_onehot(rx_sel);
              push_msg_q <= rx_data;
            end else begin
              state_q    <= PULL;
              pull_rdy_q <= chan_onehot(rx_sel);
            end
          end else if (frame_ok) begin
            pend_val_q <= 1'b0;
          end
        end
        PUSH: begin
          if (|(push_val_q & push_rdy)) begin
            push_val_q <= '0;
            parity_q   <= ^push_msg_q;
            pull_rdy_q <= chan_onehot(sel_q);
            state_q    <= PULL;
          end
        end
        PULL: begin
          pull_rdy_q <= '0;
          state_q    <= IDLE;
          if (|(pull_rdy_q & pull_val)) begin
            pend_val_q  <= 1'b1;
            pend_chan_q <= sel_q;
            pend_data_q <= pull_sel_msg;
          end else begin
            pend_val_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push_val      = push_val_q;
  assign push_msg      = push_msg_q;
  // Acknowledge only when the channel actually offers a response
  assign pull_rdy      = pull_rdy_q & pull_val;
  assign minion_parity = parity_q;
  assign err_count     = err_q;
  assign spi_min_miso  = loopthrough_sel ? mosi_s : miso_sr_q[FRAME_BITS-1];
  assign miso_oeb      = cs_s;

endmodule

// File: tb/tb_spi_minion_chan_mux.sv
module tb_spi_minion_chan_mux;
  localparam int HP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sclk, mosi, cs_a, cs_b, lt_a;
  logic        miso_a, oeb_a, par_a;
  logic [3:0]  push_val_a, push_rdy_a, pull_val_a, pull_rdy_a;
  logic [31:0] push_msg_a;
  logic [127:0] pull_msg_a;
  logic [7:0]  err_a;
  logic        miso_b, oeb_b, par_b;
  logic [2:0]  push_val_b, push_rdy_b, pull_val_b, pull_rdy_b;
  logic [31:0] push_msg_b;
  logic [95:0] pull_msg_b;
  logic [1:0]  err_b;

  int checks = 0, errors = 0, viol = 0;

  spi_minion_chan_mux dut_a (
    .clk(clk), .reset(reset), .spi_min_cs(cs_a), .spi_min_sclk(sclk), .spi_min_mosi(mosi),
    .spi_min_miso(miso_a), .miso_oeb(oeb_a), .loopthrough_sel(lt_a),
    .push_val(push_val_a), .push_msg(push_msg_a), .push_rdy(push_rdy_a),
    .pull_val(pull_val_a), .pull_msg(pull_msg_a), .pull_rdy(pull_rdy_a),
    .minion_parity(par_a), .err_count(err_a));

  spi_minion_chan_mux #(.NUM_CH(3), .DATA_BITS(32), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .spi_min_cs(cs_b), .spi_min_sclk(sclk), .spi_min_mosi(mosi),
    .spi_min_miso(miso_b), .miso_oeb(oeb_b), .loopthrough_sel(1'b0),
    .push_val(push_val_b), .push_msg(push_msg_b), .push_rdy(push_rdy_b),
    .pull_val(pull_val_b), .pull_msg(pull_msg_b), .pull_rdy(pull_rdy_b),
    .minion_parity(par_b), .err_count(err_b));

  // Bus rules on dut_a: one-hot push/pull, push_val stable until accepted
  logic [3:0] pv_prev = '0;
  logic       fire_prev = 1'b0;
  always @(negedge clk) begin
    #1;
    if (reset === 1'b1) begin
      if ($countones(push_val_a) > 1 || $countones(pull_rdy_a) > 1) viol++;
      if (pv_prev != 4'd0 && !fire_prev && push_val_a != pv_prev) viol++;
    end
    pv_prev   = push_val_a;
    fire_prev = |(push_val_a & push_rdy_a);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits of 'bits' MSB first; returns MISO sampled just before each sclk rise
  task automatic spi_frame(input bit to_b, input int nbits, input logic [63:0] bits,
                           output logic [63:0] rx);
    rx = '0;
    if (to_b) cs_b = 1'b0; else cs_a = 1'b0;
    wait_clks(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clks(HP);
      rx[i] = to_b ? miso_b : miso_a;
      sclk = 1'b1;
      wait_clks(HP);
      sclk = 1'b0;
    end
    wait_clks(HP);
    if (to_b) cs_b = 1'b1; else cs_a = 1'b1;
    mosi = 1'b0;
    wait_clks(8);
  endtask

  function automatic logic [63:0] mkframe(input bit v, input int sel, input logic [31:0] d);
    return {29'd0, v, 2'(sel), d};
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Reference model of the pending response and error counts
  logic        ep_val;
  int          ep_chan;
  logic [31:0] ep_data;
  int          exp_err_a, exp_err_b;

  initial begin
    logic [63:0] rx, fr;
    logic [31:0] d, d1, d2;
    logic [3:0]  pat, oh;
    logic [31:0] pm;
    int ch, dly;
    bit v;

    reset = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1; lt_a = 1'b0;
    push_rdy_a = '0; pull_val_a = '0; pull_msg_a = '0;
    push_rdy_b = '0; pull_val_b = '0; pull_msg_b = '0;
    ep_val = 1'b0; ep_chan = 0; ep_data = '0; exp_err_a = 0; exp_err_b = 0;
    wait_clks(3);
    check("rst_push_val", 64'(push_val_a), 64'd0);
    check("rst_pull_rdy", 64'(pull_rdy_a), 64'd0);
    check("rst_push_msg", 64'(push_msg_a), 64'd0);
    check("rst_parity",   64'(par_a), 64'd0);
    check("rst_err",      64'(err_a), 64'd0);
    check("rst_miso",     64'(miso_a), 64'd0);
    check("rst_oeb",      64'(oeb_a), 64'd1);
    check("rst_oeb_b",    64'(oeb_b), 64'd1);
    reset = 1'b1;
    wait_clks(3);

    // Push DEADBEEF to channel 2 with delayed ready
    d = 32'hDEADBEEF;
    spi_frame(0, 35, mkframe(1, 2, d), rx);
    check("first_resp", rx, mkframe(ep_val, ep_chan, ep_data));
    check("push2_val", 64'(push_val_a), 64'h4);
    check("push2_msg", 64'(push_msg_a), 64'(d));
    for (int i = 0; i < 5; i++) begin
      wait_clks(1);
      check("push2_hold", 64'(push_val_a), 64'h4);
    end
    pull_msg_a[64 +: 32] = 32'h12345678;
    pull_val_a = 4'b0100;
    push_rdy_a = 4'b0100;
    wait_clks(1);
    check("push2_drop", 64'(push_val_a), 64'd0);
    check("pull2_rdy",  64'(pull_rdy_a), 64'h4);
    check("push2_par",  64'(par_a), 64'(^d));
    wait_clks(1);
    check("pull2_done", 64'(pull_rdy_a), 64'd0);
    ep_val = 1'b1; ep_chan = 2; ep_data = 32'h12345678;
    push_rdy_a = '0; pull_val_a = '0;
    check("push2_err", 64'(err_a), 64'd0);

    // Poll channel 1 (no response offered) returns the channel 2 response
    spi_frame(0, 35, mkframe(0, 1, 32'd0), rx);
    check("poll_resp", rx, mkframe(ep_val, ep_chan, ep_data));
    check("poll_pull_rdy", 64'(pull_rdy_a), 64'd0);
    ep_val = 1'b0;

    // Randomised transactions
    for (int t = 0; t < 6; t++) begin
      v  = 1'($urandom_range(0, 1));
      ch = $urandom_range(0, 3);
      d  = $urandom;
      pull_val_a = 4'($urandom_range(0, 15));
      pull_msg_a = {$urandom, $urandom, $urandom, $urandom};
      push_rdy_a = '0;
      spi_frame(0, 35, mkframe(v, ch, d), rx);
      check("rnd_resp", rx, mkframe(ep_val, ep_chan, ep_data));
      if (v) begin
        oh = 4'(1 << ch);
        check("rnd_push_val", 64'(push_val_a), 64'(oh));
        check("rnd_push_msg", 64'(push_msg_a), 64'(d));
        dly = $urandom_range(0, 3);
        for (int k = 0; k < dly; k++) begin
          wait_clks(1);
          check("rnd_push_hold", 64'(push_val_a), 64'(oh));
        end
        push_rdy_a = 4'($urandom_range(0, 15)) | oh;
        wait_clks(1);
        check("rnd_push_drop", 64'(push_val_a), 64'd0);
        check("rnd_parity", 64'(par_a), 64'(^d));
        wait_clks(2);
      end
      if (pull_val_a[ch]) begin
        ep_val = 1'b1; ep_chan = ch; ep_data = pull_msg_a[ch*32 +: 32];
      end else begin
        ep_val = 1'b0;
      end
      push_rdy_a = '0;
      check("rnd_err", 64'(err_a), 64'(exp_err_a));
    end
    pull_val_a = '0;

    // Short and long frames are dropped
    spi_frame(0, 20, {$urandom, $urandom}, rx);
    exp_err_a = sat(exp_err_a + 1, 255);
    check("short_err", 64'(err_a), 64'(exp_err_a));
    check("short_push", 64'(push_val_a), 64'd0);
    spi_frame(0, 40, {$urandom, $urandom}, rx);
    exp_err_a = sat(exp_err_a + 1, 255);
    check("long_err", 64'(err_a), 64'(exp_err_a));
    check("long_push", 64'(push_val_a), 64'd0);

    // Loopthrough: MOSI echoed with two clocks of latency
    lt_a = 1'b1;
    pm = push_msg_a;
    pat = 4'b1011;
    mosi = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 6; i++) begin
      wait_clks(1);
      if (i == 1) check("lt_lat", 64'(miso_a), 64'd0);
      if (i >= 2) check("lt_echo", 64'(miso_a), 64'(pat[5-i]));
      if (i < 4) mosi = pat[3-i];
    end
    mosi = 1'b0;
    wait_clks(4);
    fr = mkframe(1, 0, $urandom);
    spi_frame(0, 35, fr, rx);
    check("lt_frame_echo", rx, fr);
    check("lt_push", 64'(push_val_a), 64'd0);
    check("lt_err", 64'(err_a), 64'(exp_err_a));
    check("lt_msg", 64'(push_msg_a), 64'(pm));
    spi_frame(0, 10, 64'h2A5, rx);
    check("lt_short_err", 64'(err_a), 64'(exp_err_a));
    cs_a = 1'b0;
    wait_clks(4);
    check("oeb_sel", 64'(oeb_a), 64'd0);
    cs_a = 1'b1;
    wait_clks(4);
    check("oeb_desel", 64'(oeb_a), 64'd1);
    lt_a = 1'b0;
    wait_clks(4);

    // Reset during a push
    push_rdy_a = '0;
    d = $urandom;
    spi_frame(0, 35, mkframe(1, 3, d), rx);
    check("prerst_resp", rx, mkframe(ep_val, ep_chan, ep_data));
    check("prerst_push", 64'(push_val_a), 64'h8);
    reset = 1'b0;
    #1;
    check("rst_async_push", 64'(push_val_a), 64'd0);
    check("rst_async_err", 64'(err_a), 64'd0);
    wait_clks(2);
    reset = 1'b1;
    ep_val = 1'b0; ep_chan = 0; ep_data = '0; exp_err_a = 0; exp_err_b = 0;
    wait_clks(2);
    push_rdy_a = 4'b0010;
    d = $urandom;
    spi_frame(0, 35, mkframe(1, 1, d), rx);
    check("postrst_resp", rx, mkframe(ep_val, ep_chan, ep_data));
    check("postrst_push", 64'(push_val_a), 64'd0);
    check("postrst_msg", 64'(push_msg_a), 64'(d));
    check("postrst_par", 64'(par_a), 64'(^d));
    check("postrst_err", 64'(err_a), 64'd0);
    push_rdy_a = '0;

    // Three-channel instance: out-of-range select, busy drop, saturation
    push_rdy_b = '0;
    spi_frame(1, 35, mkframe(1, 3, $urandom), rx);
    exp_err_b = sat(exp_err_b + 1, 3);
    check("oor_push", 64'(push_val_b), 64'd0);
    check("oor_err", 64'(err_b), 64'(exp_err_b));
    spi_frame(1, 35, mkframe(0, 3, 32'd0), rx);
    exp_err_b = sat(exp_err_b + 1, 3);
    check("oor_poll_err", 64'(err_b), 64'(exp_err_b));
    d1 = $urandom;
    d2 = $urandom;
    spi_frame(1, 35, mkframe(1, 0, d1), rx);
    check("b_push_val", 64'(push_val_b), 64'h1);
    spi_frame(1, 35, mkframe(1, 1, d2), rx);
    exp_err_b = sat(exp_err_b + 1, 3);
    check("busy_err", 64'(err_b), 64'(exp_err_b));
    check("busy_push_val", 64'(push_val_b), 64'h1);
    check("busy_push_msg", 64'(push_msg_b), 64'(d1));
    push_rdy_b = 3'b001;
    wait_clks(1);
    check("b_push_drop", 64'(push_val_b), 64'd0);
    check("b_parity", 64'(par_b), 64'(^d1));
    push_rdy_b = '0;
    wait_clks(3);
    for (int i = 0; i < 2; i++) begin
      spi_frame(1, 5, 64'h15, rx);
      exp_err_b = sat(exp_err_b + 1, 3);
    end
    check("sat_err", 64'(err_b), 64'(exp_err_b));
    check("sat_push", 64'(push_val_b), 64'd0);

    check("bus_rules", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_minion_chan_mux.md
Name: spi_minion_chan_mux

Overview:
- Parametrised successor to the per-group SPI tapeout blocks. One SPI minion pad set serves NUM_CH internal channels instead of one block per pad group.
- Each SPI frame carries a channel select, a valid bit and a data word.
- The block pushes frame data into the addressed channel over val/rdy. It pulls that channel's response and returns it on MISO during the next frame.
- Also provides loopthrough mode, a parity observation pin and pad output-enables.

Parameters:
- NUM_CH, 4, number of internal channels (2..16).
- DATA_BITS, 32, payload width per frame.
- ERR_W, 8, width of the saturating error counter.
- Derived, not overridable: SEL_W = max(1, clog2(NUM_CH)); FRAME_BITS = 1 + SEL_W + DATA_BITS.

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- spi_min_cs  in  1  chip select, active low; asynchronous to clk.
- spi_min_sclk  in  1  SPI clock, asynchronous; required to be at most clk/4.
- spi_min_mosi  in  1  serial data in.
- spi_min_miso  out  1  serial data out.
- miso_oeb  out  1  pad output-enable bar for MISO.
- loopthrough_sel  in  1  1 = loopthrough mode.
- push_val  out  NUM_CH  one-hot push valid, one bit per channel.
- push_msg  out  DATA_BITS  push payload, shared across channels.
- push_rdy  in  NUM_CH  per-channel ready.
- pull_val  in  NUM_CH  per-channel response valid.
- pull_msg  in  NUM_CH*DATA_BITS  responses; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
- pull_rdy  out  NUM_CH  one-hot, one-cycle pull acknowledge.
- minion_parity  out  1  XOR reduction of the last pushed payload.
- err_count  out  ERR_W  saturating error counter.

Behaviour:
- Synchronisation: cs, sclk and mosi each pass through a 2-flop synchroniser. Edges are detected on the synchronised sclk and cs.
- Frame format, MSB first:
  - MOSI: {val, sel[SEL_W-1:0], data}.
  - MISO: {resp_val, resp_chan, resp_data}.
- Sampling: MOSI is sampled on synchronised sclk rise. MISO shifts on synchronised sclk fall.
- cs fall: load the MISO shift register with {pend_val, pend_chan, pend_data} and clear bit_cnt. The first MISO bit is valid before the first sclk rise.
- Bit counting: bit_cnt saturates at FRAME_BITS+1. Bits beyond FRAME_BITS are ignored.
- cs rise: the frame is accepted only if bit_cnt == FRAME_BITS and the state is IDLE. Otherwise the frame is dropped and err_count increments.
- State machine: IDLE, PUSH, PULL.
  - IDLE -> PUSH: accepted frame with val=1 and sel<NUM_CH.
  - IDLE -> PULL: accepted frame with val=0 (poll) and sel<NUM_CH.
  - Accepted frame with sel>=NUM_CH: err_count increments, pend_val<=0, state stays IDLE.
  - PUSH: push_val[sel]=1 and push_msg=data are held stable until push_rdy[sel]. In that fire cycle, minion_parity <= ^data and the state moves to PULL.
  - PULL, exactly one cycle:
    - If pull_val[sel]: pull_rdy[sel]=1 for that cycle, pend_data <= pull_msg slice, pend_chan <= sel, pend_val <= 1.
    - Else: pend_val <= 0.
    - Then IDLE.
- Response latency: a response captured after frame N is shifted out during frame N+1.
- Bus-mastering rules:
  - At most one push_val bit and one pull_rdy bit are high in any cycle.
  - push_val never drops before push_rdy.
  - Payload bits never reach push_msg while loopthrough_sel=1.
- Error counter: err_count saturates at 2^ERR_W-1. Simultaneous error sources in one cycle count once.
- cs toggled mid-push (state PUSH): the in-progress push completes normally. The new frame is dropped at its cs rise if the state is still not IDLE.
- Loopthrough (loopthrough_sel=1):
  - spi_min_miso = synchronised mosi (2-cycle latency).
  - Completed frames cause no push, pull or error.
  - FSM state is unchanged; an in-flight PUSH still completes.
- miso_oeb = synchronised cs: 1 (tristate) when deselected, 0 (driven) when selected.
- Reset (asynchronous assert, synchronous deassert via the flops):
  - Outputs: push_val=0, pull_rdy=0, push_msg=0, minion_parity=0, err_count=0, spi_min_miso=0, miso_oeb=1.
  - Internal state: FSM IDLE, pend_val=0, pend_chan=0, pend_data=0, synchronisers cleared to idle levels (cs=1, sclk=0).
  - Reset mid-frame or mid-push aborts with no further handshake.

Test Plan:
- Push to channel 2: defaults (NUM_CH=4, DATA_BITS=32, FRAME_BITS=35), frame {1, 2'd2, 32'hDEADBEEF}, push_rdy[2] held low 5 cycles -> push_val=4'b0100 held 5 cycles, push_msg=DEADBEEF, parity=0 after fire, err_count=0.
- Response path: pull_val[2]=1 with msg 32'h12345678 during PULL, then a poll frame {0, 2'd1, 0} -> MISO returns {1, 2'd2, 32'h12345678}. pull_val[1]=0, so the next frame returns resp_val=0.
- Short frame (20 bits), then long frame (40 bits) -> both dropped, no push, err_count=2. ERR_W=2 with 5 errors -> saturates at 3.
- Out-of-range select: NUM_CH=3, frame sel=3 -> no push/pull, err_count+1. Second frame sent while push_rdy is held low -> dropped, err_count+1, first push still completes.
- Loopthrough: loopthrough_sel=1, MOSI pattern 1011 -> MISO echoes 1011 delayed 2 clk, push_val stays 0, err_count unchanged. miso_oeb follows cs.
- Reset asserted mid-push (push_val high) -> push_val=0 immediately (asynchronous). After release a fresh frame works and the first response has resp_val=0.
